gear_shift_sequencer: RTL
=========================

Name: gear_shift_sequencer

Overview:
Registered controller that sequences the P/R/N/D gear selector and the four drive sub-gears.
- Debounces the raw selector switches.
- Enforces safety interlocks (brake, zero speed) on mode changes.
- Schedules automatic D1..D4 up/downshifts from a speed input with dwell time and hysteresis.
- Drives the same 7-bit indicator bus the top level uses: {R1,N1,P1,D4,D3,D2,D1}.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive stable cycles required before a selector value is a request.
- DWELL_CYCLES, 64: minimum cycles in a drive gear before any automatic shift.
- UP_T1, 20: speed at or above which D1 shifts to D2.
- UP_T2, 40: speed at or above which D2 shifts to D3.
- UP_T3, 60: speed at or above which D3 shifts to D4.
- HYST, 5: downshift hysteresis, in speed units.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- sw  input  4  raw selector {P,R,N,D}.
- brake  input  1  brake pedal pressed, level.
- speed  input  8  unsigned vehicle speed, sampled every clk.
- mode  output  2  00=P, 01=R, 10=N, 11=D.
- gear  output  3  0 when mode!=D, else 1..4.
- led  output  7  {R1,N1,P1,D4,D3,D2,D1}, one-hot, decoded from mode/gear and registered.
- shift_pulse  output  1  one-cycle strobe on any mode or gear change.
- reject  output  1  one-cycle strobe when a selector request is refused.

Behaviour:
Reset (reset=0, asynchronous):
- mode=P, gear=0, led=7'b0010000.
- shift_pulse=0, reject=0.
- Debounce and dwell counters=0; last-accepted selector=4'b1000.

Debounce:
- A candidate sw value is valid only if it is one-hot.
- Zero or multiple bits set: counter clears, no request.
- Counter increments while sw equals the previous cycle's sw; any change clears it.
- When the count reaches DEBOUNCE_CYCLES-1 and the value differs from last-accepted, a single request is raised. Last-accepted updates whether or not the request is granted, so a refused request does not retry until the selector changes.

Request arbitration (registered; outputs update the cycle after the request is raised):
- To P or R: requires speed==0 and brake=1.
- To N: always granted.
- To D from P: requires brake=1.
- To D from R: requires speed==0 and brake=1.
- To D from N: always granted.
- Request equal to the current mode: no action, no pulse.
- Refused: reject=1 for one cycle; mode and gear hold.
- Granted: mode updates, shift_pulse=1. gear=1 if entering D, else 0. Dwell counter clears.

Auto-shift (only while mode=D):
- Dwell counter saturates at DWELL_CYCLES-1. Shifts are allowed only when saturated.
- Upshift when gear<4 and speed>=UP_T(gear).
- Downshift when gear>1 and speed+HYST < UP_T(gear-1). Compare at 9-bit width: no wrap at speed=255.
- One step per event. Each shift clears the dwell counter and raises shift_pulse.
- Thresholds must be strictly increasing; otherwise behaviour is undefined.

Simultaneous events:
- A granted selector request and an auto-shift in the same cycle: the selector request wins and the auto-shift is dropped.
- Refused request and auto-shift together: reject=1 and the auto-shift proceeds; both strobes may be high.

Reset mid-shift returns to the reset state immediately. Latency from stable sw to the mode change is DEBOUNCE_CYCLES+1 cycles.

Optional Feature:
REJECT_CNT_EN
- Defined: adds output reject_cnt[7:0], an 8-bit saturating count of reject strobes. Saturates at 255 and clears only on reset.
- Undefined: neither the port nor the counter exists. All other behaviour is identical.

Test Plan:
- Reset release, sw=4'b1000 -> mode=00, gear=0, led=7'b0010000, no strobes.
- From P: brake=1, speed=0, sw=4'b0001 held 16 cycles -> on cycle 17 mode=11, gear=1, led=7'b0000001, shift_pulse for 1 cycle.
- In D1, speed=25 after 64 cycles dwell -> gear=2, led=7'b0000010. Speed=70 -> D3 after 64 more cycles, then D4. Speed drops to 54 -> D3 after dwell (54+5<60).
- In D, speed=30, sw->4'b0100 (R) stable -> reject for 1 cycle, mode stays 11. With REJECT_CNT_EN, reject_cnt=1.
- sw=4'b0011 held 40 cycles -> no request, no strobes. sw glitching every 10 cycles -> no request.
- Assert reset=0 in D3 mid-dwell -> outputs return to reset values asynchronously, before the next clk edge.

Source files
------------

// File: rtl/gear_shift_sequencer.sv
// Registered P/R/N/D selector controller with debounce, safety interlocks and D1..D4 auto-shift.
// Optional: define REJECT_CNT_EN to add an 8-bit saturating reject_cnt output.
module gear_shift_sequencer #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int DWELL_CYCLES    = 64,
    parameter int UP_T1           = 20,
    parameter int UP_T2           = 40,
    parameter int UP_T3           = 60,
    parameter int HYST            = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] sw,
    input  logic       brake,
    input  logic [7:0] speed,
    output logic [1:0] mode,
    output logic [2:0] gear,
    output logic [6:0] led,
    output logic       shift_pulse,
    output logic       reject
`ifdef REJECT_CNT_EN
    ,
    output logic [7:0] reject_cnt
`endif
);

    localparam logic [1:0] MODE_P = 2'b00;
    localparam logic [1:0] MODE_R = 2'b01;
    localparam logic [1:0] MODE_N = 2'b10;
    localparam logic [1:0] MODE_D = 2'b11;

    localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int DW_W = (DWELL_CYCLES > 2) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DW_W-1:0] DW_MAX = DW_W'(DWELL_CYCLES - 1);
    localparam logic [8:0]      HYST9  = 9'(HYST);

    function automatic logic [1:0] sel_mode(input logic [3:0] s);
        case (s)
            4'b1000: sel_mode = MODE_P;
            4'b0100: sel_mode = MODE_R;
            4'b0010: sel_mode = MODE_N;
            default: sel_mode = MODE_D;
        endcase
    endfunction

    function automatic logic [8:0] up_thr(input logic [2:0] g);
        case (g)
            3'd1:    up_thr = 9'(UP_T1);
            3'd2:    up_thr = 9'(UP_T2);
            3'd3:    up_thr = 9'(UP_T3);
            default: up_thr = 9'h1ff;
        endcase
    endfunction

    function automatic logic [6:0] led_of(input logic [1:0] m, input logic [2:0] g);
        case (m)
            MODE_P: led_of = 7'b0010000;
            MODE_R: led_of = 7'b1000000;
            MODE_N: led_of = 7'b0100000;
            default: begin
                case (g)
                    3'd1:    led_of = 7'b0000001;
                    3'd2:    led_of = 7'b0000010;
                    3'd3:    led_of = 7'b0000100;
                    3'd4:    led_of = 7'b0001000;
                    default: led_of = 7'b0000000;
                endcase
            end
        endcase
    endfunction

    logic [3:0]      sw_prev, sw_acc;
    logic [DB_W-1:0] db_cnt, db_cnt_nxt;
    logic            sw_onehot, db_fire;
    logic            req_vld;
    logic [1:0]      req_mode;
    logic [DW_W-1:0] dwell, dwell_nxt;
    logic [1:0]      mode_nxt;
    logic [2:0]      gear_nxt;
    logic            pulse_nxt, reject_nxt;
    logic            grant_ok, up_ok, down_ok;
    logic [8:0]      speed9;

    assign speed9    = {1'b0, speed};
    assign sw_onehot = (sw != 4'd0) && ((sw & (sw - 4'd1)) == 4'd0);

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        db_cnt_nxt = '0;
        if (sw_onehot && (sw == sw_prev))
            db_cnt_nxt = (db_cnt == DB_MAX) ? db_cnt : db_cnt + DB_W'(1);
    end

    // A new value fires exactly once, on the cycle its count first reaches the limit.
    assign db_fire = sw_onehot && (db_cnt_nxt == DB_MAX) && (sw != sw_acc);

    always_comb begin
        grant_ok = 1'b0;
        case (req_mode)
            MODE_P, MODE_R: grant_ok = (speed == 8'd0) && brake;
            MODE_N:         grant_ok = 1'b1;
            default: begin
                case (mode)
                    MODE_P:  grant_ok = brake;
                    MODE_R:  grant_ok = (speed == 8'd0) && brake;
                    default: grant_ok = 1'b1;
                endcase
            end
        endcase
    end

    assign up_ok   = (gear < 3'd4) && (speed9 >= up_thr(gear));
    assign down_ok = (gear > 3'd1) && ((speed9 + HYST9) < up_thr(gear - 3'd1));

    always_comb begin
        mode_nxt   = mode;
        gear_nxt   = gear;
        dwell_nxt  = dwell;
        pulse_nxt  = 1'b0;
        reject_nxt = 1'b0;
        if (req_vld && (req_mode != mode) && grant_ok) begin
            mode_nxt  = req_mode;
            gear_nxt  = (req_mode == MODE_D) ? 3'd1 : 3'd0;
            dwell_nxt = '0;
            pulse_nxt = 1'b1;
        end else begin
            reject_nxt = req_vld && (req_mode != mode);
            // A refused request does not block the auto-shift scheduler.
            if (mode == MODE_D) begin
                if (dwell != DW_MAX) begin
                    dwell_nxt = dwell + DW_W'(1);
                end else if (up_ok) begin
                    gear_nxt  = gear + 3'd1;
                    dwell_nxt = '0;
                    pulse_nxt = 1'b1;
                end else if (down_ok) begin
                    gear_nxt  = gear - 3'd1;
                    dwell_nxt = '0;
                    pulse_nxt = 1'b1;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sw_prev     <= 4'b1000;
            sw_acc      <= 4'b1000;
            db_cnt      <= '0;
            req_vld     <= 1'b0;
            req_mode    <= MODE_P;
            dwell       <= '0;
            mode        <= MODE_P;
            gear        <= 3'd0;
            led         <= 7'b0010000;
            shift_pulse <= 1'b0;
            reject      <= 1'b0;
        end else begin
            sw_prev     <= sw;
            db_cnt      <= db_cnt_nxt;
            req_vld     <= db_fire;
            if (db_fire) begin
                sw_acc   <= sw;
                req_mode <= sel_mode(sw);
            end
            dwell       <= dwell_nxt;
            mode        <= mode_nxt;
            gear        <= gear_nxt;
            led         <= led_of(mode_nxt, gear_nxt);
            shift_pulse <= pulse_nxt;
            reject      <= reject_nxt;
        end
    end

`ifdef REJECT_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            reject_cnt <= 8'd0;
        else if (reject_nxt && (reject_cnt != 8'hff))
            reject_cnt <= reject_cnt + 8'd1;
    end
`endif

endmodule
